// File: rtl/ts_fifo_sc.sv
// ts_fifo_sc: single-clock show-ahead timestamp FIFO with overflow reporting.
// Define TS_FIFO_DROP_CNT_EN to build the saturating dropped-write counter.
module ts_fifo_sc #(
   parameter int DATA_W     = 80,
   parameter int DEPTH_LOG2 = 4,
   parameter int AFULL_LVL  = 12
) (
   input  logic                clk,
   input  logic                aclr_n,
   input  logic                flush,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DEPTH_LOG2:0] usedw,
   output logic                full,
   output logic                afull,
   output logic                ovf,
   output logic [15:0]         drop_cnt
);

   localparam int CW = DEPTH_LOG2 + 1;
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         usedw_q, usedw_d;
   logic                  push, pop, drop;

   // Status flags come only from the registered fill count.
   assign full      = (usedw_q == DEPTH_C);
   assign in_ready  = ~full;
   assign afull     = (usedw_q >= AFULL_C);
   assign out_valid = (usedw_q != '0);
   assign usedw     = usedw_q;
   assign out_data  = mem_q[rd_ptr_q];
   assign ovf       = drop;

   // Handshake qualification and next-state pointer/count; flush wins.
   always_comb begin
      push     = in_valid & ~full & ~flush;
      pop      = out_valid & out_ready & ~flush;
      drop     = in_valid & full & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      usedw_d  = usedw_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         usedw_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         unique case ({push, pop})
            2'b10:   usedw_d = usedw_q + CNT_ONE;
            2'b01:   usedw_d = usedw_q - CNT_ONE;
            default: usedw_d = usedw_q;
         endcase
      end
   end

   // Pointer and fill-count registers.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
      end
   end

   // Storage array; contents survive reset and flush.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

`ifdef TS_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of writes discarded while full.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   // Dropped-write counter register; only reset clears it.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) drop_cnt_q <= '0;
      else         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ts_fifo_sc.sv
// tb_ts_fifo_sc: scoreboard bench for ts_fifo_sc with a queue-based model.
// Honours TS_FIFO_DROP_CNT_EN for the expected drop_cnt value.
module tb_ts_fifo_sc;

   localparam int DW = 80;
   localparam int DL = 4;
   localparam int DEPTH = 16;
   localparam int AFL = 12;

   logic          clk = 1'b0;
   logic          aclr_n = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DL:0]   usedw;
   logic          full, afull, ovf;
   logic [15:0]   drop_cnt;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] exp_q [$];
   int            drop_m = 0;

   ts_fifo_sc #(.DATA_W(DW), .DEPTH_LOG2(DL), .AFULL_LVL(AFL)) dut (
      .clk(clk), .aclr_n(aclr_n), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .usedw(usedw), .full(full), .afull(afull), .ovf(ovf),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      return {16'($urandom), $urandom, $urandom};
   endfunction

   function automatic logic [15:0] exp_drop();
`ifdef TS_FIFO_DROP_CNT_EN
      return 16'(drop_m);
`else
      return 16'h0;
`endif
   endfunction

   // Reference model: a plain queue of accepted words plus a drop tally.
   always @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         exp_q.delete();
         drop_m = 0;
      end else if (flush) begin
         exp_q.delete();
      end else begin
         int n;
         n = exp_q.size();
         if (out_ready && n > 0) void'(exp_q.pop_front());
         if (in_valid && n < DEPTH) exp_q.push_back(in_data);
         if (in_valid && n == DEPTH && drop_m < 65535) drop_m++;
      end
   end

   // Monitor: compare every visible output against the model mid-cycle.
   always @(negedge clk) begin
      int n;
      n = exp_q.size();
      chk("usedw", DW'(usedw), DW'(n));
      chk("out_valid", DW'(out_valid), DW'(n > 0));
      chk("full", DW'(full), DW'(n == DEPTH));
      chk("in_ready", DW'(in_ready), DW'(n != DEPTH));
      chk("afull", DW'(afull), DW'(n >= AFL));
      chk("ovf", DW'(ovf),
          DW'(aclr_n && in_valid && !flush && n == DEPTH));
      chk("drop_cnt", DW'(drop_cnt), DW'(exp_drop()));
      if (n > 0) chk("out_data", out_data, exp_q[0]);
   end

   task automatic cyc(input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
      in_valid = iv;
      in_data = d;
      out_ready = ordy;
      flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0;
      out_ready = 0;
      flush = 0;
      #2 aclr_n = 0;
      #1;
      chk("rst_usedw", DW'(usedw), '0);
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_in_ready", DW'(in_ready), DW'(1));
      chk("rst_full", DW'(full), '0);
      chk("rst_afull", DW'(afull), '0);
      chk("rst_ovf", DW'(ovf), '0);
      chk("rst_drop_cnt", DW'(drop_cnt), '0);
      @(negedge clk);
      #2 aclr_n = 1;
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] wa, wb, wc;
   int ndrop;

   initial begin
      do_reset();

      wa = rnd(); wb = rnd(); wc = rnd();
      cyc(1, wa, 0, 0);
      cyc(1, wb, 0, 0);
      cyc(1, wc, 0, 0);
      chk("abc_usedw", DW'(usedw), DW'(3));
      chk("abc_head", out_data, wa);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
      chk("abc_empty", DW'(out_valid), '0);
      cyc(0, '0, 1, 0);

      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, rnd(), 0, 0);
         if (i == AFL - 2) chk("afull_11", DW'(afull), '0);
         if (i == AFL - 1) chk("afull_12", DW'(afull), DW'(1));
      end
      chk("full_16", DW'(full), DW'(1));
      chk("in_ready_16", DW'(in_ready), '0);
      cyc(1, rnd(), 0, 0);
      cyc(1, rnd(), 0, 0);
      cyc(0, '0, 0, 0);
`ifdef TS_FIFO_DROP_CNT_EN
      chk("drop_2", DW'(drop_cnt), DW'(2));
`else
      chk("drop_2", DW'(drop_cnt), '0);
`endif
      for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1, 0);

      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc(1, rnd(), 0, 0);
      cyc(1, rnd(), 1, 0);
      chk("pushpop_full_usedw", DW'(usedw), DW'(15));
`ifdef TS_FIFO_DROP_CNT_EN
      chk("pushpop_full_drop", DW'(drop_cnt), DW'(1));
`else
      chk("pushpop_full_drop", DW'(drop_cnt), '0);
`endif
      for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1, 0);

      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, rnd(), 0, 0);
      for (int i = 0; i < 40; i++) cyc(1, rnd(), 1, 0);
      chk("steady_usedw", DW'(usedw), DW'(5));
      for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0);

      for (int i = 0; i < DEPTH + 3; i++) cyc(1, rnd(), 0, 0);
      for (int i = 0; i < 9; i++) cyc(0, '0, 1, 0);
      chk("pre_flush_usedw", DW'(usedw), DW'(7));
      cyc(1, rnd(), 1, 1);
      chk("flush_usedw", DW'(usedw), '0);
      chk("flush_out_valid", DW'(out_valid), '0);
`ifdef TS_FIFO_DROP_CNT_EN
      chk("flush_drop", DW'(drop_cnt), DW'(3));
`else
      chk("flush_drop", DW'(drop_cnt), '0);
`endif

      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 99) < 60, rnd(),
             $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);

      cyc(0, '0, 0, 1);
      for (int i = 0; i < DEPTH; i++) cyc(1, rnd(), 0, 0);
`ifdef TS_FIFO_DROP_CNT_EN
      ndrop = 66000;
`else
      ndrop = 300;
`endif
      for (int i = 0; i < ndrop; i++) cyc(1, rnd(), 0, 0);
`ifdef TS_FIFO_DROP_CNT_EN
      chk("drop_sat", DW'(drop_cnt), DW'(16'hFFFF));
`else
      chk("drop_sat", DW'(drop_cnt), '0);
`endif
      cyc(1, rnd(), 1, 0);
      cyc(1, rnd(), 1, 0);
      do_reset();
      cyc(1, rnd(), 0, 0);
      chk("post_rst_usedw", DW'(usedw), DW'(1));
      cyc(0, '0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ts_fifo_sc.md
Name: ts_fifo_sc

Overview:
- Single-clock, parametrised timestamp FIFO; successor to the fixed 80-bit x16 dual-clock timestamp FIFO.
- Buffers captured PTP timestamp words between the timestamp capture unit and the consumer (packet tagger / CSR readout).
- Adds valid/ready handshakes, a show-ahead output, a full-range fill count, an almost-full flag, synchronous flush and overflow reporting.

Parameters:
- DATA_W, 80, width of one timestamp word.
- DEPTH_LOG2, 4, log2 of entry count; depth = 2**DEPTH_LOG2.
- AFULL_LVL, 12, fill level at or above which afull asserts; legal range 1..2**DEPTH_LOG2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- in_data  in  DATA_W  write word.
- in_valid  in  1  write request.
- in_ready  out  1  write accepted when high; equals !full.
- out_data  out  DATA_W  head word (show-ahead); valid only while out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  pop head when out_valid=1.
- usedw  out  DEPTH_LOG2+1  number of stored words, 0..2**DEPTH_LOG2 (no wrap at full).
- full  out  1  usedw == 2**DEPTH_LOG2.
- afull  out  1  usedw >= AFULL_LVL.
- ovf  out  1  one-cycle pulse when a write is dropped.
- drop_cnt  out  16  saturating count of dropped writes.

Behaviour:
- Reset (aclr_n=0, asynchronous): pointers=0, usedw=0, out_valid=0, in_ready=1, full=0, afull=0, ovf=0, drop_cnt=0. out_data is don't-care. Memory contents are not cleared.
- Storage: register array of 2**DEPTH_LOG2 x DATA_W. Write and read pointers are DEPTH_LOG2 bits and wrap naturally.
- Push = in_valid & in_ready. The word is written at wr_ptr and wr_ptr increments.
- Pop = out_valid & out_ready. rd_ptr increments.
- out_data = mem[rd_ptr], read combinationally (show-ahead).
- Latency: a word pushed at edge N gives out_valid=1 and the correct out_data in the cycle after edge N.
- usedw: +1 on push only, -1 on pop only, unchanged on push+pop. full, afull and out_valid are derived from the registered usedw.
- Full:
  - in_ready=0, so no write is accepted even if a pop occurs in the same cycle.
  - in_valid=1 while full: the word is discarded, ovf=1 for that cycle, drop_cnt increments and saturates at 16'hFFFF.
- Empty: out_ready is ignored and no underflow occurs. A push while empty is accepted normally.
- Simultaneous push+pop, non-empty and non-full: both are performed and usedw is unchanged. Wrap of either pointer has no side effect.
- flush=1 takes priority over push and pop:
  - At the next edge: pointers=0, usedw=0, out_valid=0.
  - Push and pop in the flush cycle are ignored.
  - ovf is not asserted.
  - drop_cnt is not cleared; only reset clears it.
- Reset asserted mid-operation returns all state to the reset values immediately. Operation resumes on the first edge after aclr_n deasserts.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

Optional Feature:
- Macro TS_FIFO_DROP_CNT_EN.
- Defined: drop_cnt logic is present as described above.
- Undefined: the counter register is removed and drop_cnt is tied to 16'h0. The ovf pulse is still generated. All other behaviour is identical.

Test Plan:
- Reset, then push 3 words A,B,C (one per cycle, out_ready=0) -> usedw=3, out_valid=1, out_data=A. Then pop 3 -> out_data A,B,C in order, then out_valid=0, usedw=0.
- Fill 16 words (defaults) -> afull=1 at usedw=12, full=1 and in_ready=0 at usedw=16. Push 2 more -> two ovf pulses, drop_cnt=2, contents unchanged.
- At full, in_valid=1 and out_ready=1 in the same cycle -> pop occurs, write dropped, usedw=15, ovf=1, drop_cnt=1.
- Continuous push+pop for 40 cycles at usedw=5 -> usedw stays 5, output order preserved across pointer wrap.
- flush at usedw=7 with concurrent push and pop -> next cycle usedw=0, out_valid=0, drop_cnt unchanged.
- Force 70000 dropped writes with the macro defined -> drop_cnt=16'hFFFF. Assert aclr_n=0 mid-stream -> all outputs return to reset values immediately.
